font_rom_arbiter: RTL and testbench

- Shares the single-port numeric font ROM between several readers on vga_clk.
- Requester 0 is the streaming VGA pixel path and has strict priority; it may issue a read every cycle.
- Requesters 1..NUM_REQ-1 are background readers (glyph cache fill, debug overlays) served round-robin in cycles requester 0 leaves idle.
- Returns ROM data with per-requester valid pulses aligned to the ROM read latency.

---
 rtl/font_rom_arbiter_if.sv | 22 ++
 rtl/font_rom_arbiter.sv | 183 ++++++++++++++++++
 tb/tb_font_rom_arbiter.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/font_rom_arbiter_if.sv
// ============================================================================
// font_rom_arbiter_if : requester-side bus of the font ROM arbiter
// Rev 1.0
// ============================================================================
`default_nettype none

interface font_rom_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 15,
  parameter int DATA_W  = 1
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*ADDR_W-1:0] addr;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        rdata_valid;
  logic [DATA_W-1:0]         rdata;

  modport master (output req, addr, input gnt, rdata_valid, rdata);
  modport slave  (input req, addr, output gnt, rdata_valid, rdata);
endinterface

`default_nettype wire

// File: rtl/font_rom_arbiter.sv
// ============================================================================
// font_rom_arbiter : shares the font ROM; requester 0 has strict priority,
// the rest are served round-robin. Optional FONT_ARB_STARVE_EN forces a
// background slot after STARVE_MAX cycles of requester-0 traffic.
// Rev 1.0
// ============================================================================
`default_nettype none

module font_rom_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int ADDR_W     = 15,
  parameter int DATA_W     = 1,
  parameter int ROM_LAT    = 1,
  parameter int STARVE_MAX = 64
) (
  input  wire logic              vga_clk,
  input  wire logic              vga_rst_n,
  font_rom_arbiter_if.slave      bus,
  output logic                   rom_en,
  output logic [ADDR_W-1:0]      rom_addra,
  input  wire logic [DATA_W-1:0] rom_douta,
  output logic                   busy
`ifdef FONT_ARB_STARVE_EN
  ,
  output logic                   starve_hit
`endif
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0] FIRST_BG = IDX_W'(1);

  logic [NUM_REQ-1:0] r_gnt;
  logic [IDX_W-1:0]   r_gnt_idx;
  logic [IDX_W-1:0]   r_rr_ptr;
  logic [DATA_W-1:0]  r_rdata;

  logic               w_rr_found;
  logic [IDX_W-1:0]   w_rr_idx;
  logic [IDX_W-1:0]   w_rr_next;
  logic               w_force;
  logic               w_grant;
  logic               w_take_bg;
  logic [IDX_W-1:0]   w_win;
  logic [ADDR_W-1:0]  w_win_addr;
  logic               w_cap;

  logic [ROM_LAT-1:0] r_pipe_vld;
  logic [IDX_W-1:0]   r_pipe_idx [ROM_LAT];

  // Round-robin scan from r_rr_ptr over 1..NUM_REQ-1; the requester granted
  // last cycle is masked so it can react to its registered gnt.
  always_comb begin
    int               cand;
    logic [IDX_W-1:0] cand_idx;
    w_rr_found = 1'b0;
    w_rr_idx   = '0;
    cand       = 0;
    cand_idx   = '0;
    for (int k = 0; k < NUM_REQ - 1; k++) begin
      cand = int'(r_rr_ptr) + k;
      if (cand > NUM_REQ - 1) begin
        cand = cand - (NUM_REQ - 1);
      end
      cand_idx = IDX_W'(cand);
      if (!w_rr_found && bus.req[cand_idx] && !r_gnt[cand_idx]) begin
        w_rr_found = 1'b1;
        w_rr_idx   = cand_idx;
      end
    end
  end

  assign w_rr_next = (w_rr_idx == LAST_IDX) ? FIRST_BG : w_rr_idx + FIRST_BG;

`ifdef FONT_ARB_STARVE_EN
  logic [7:0] r_starve_cnt;
  logic       r_starve_hit;

  assign w_force    = bus.req[0] && w_rr_found && (r_starve_cnt == 8'(STARVE_MAX));
  assign starve_hit = r_starve_hit;

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_starve_cnt <= '0;
      r_starve_hit <= 1'b0;
    end else begin
      r_starve_hit <= w_force;
      if (w_take_bg) begin
        r_starve_cnt <= '0;
      end else if (bus.req[0] && (|bus.req[NUM_REQ-1:1]) && (r_starve_cnt != 8'hFF)) begin
        r_starve_cnt <= r_starve_cnt + 8'd1;
      end
    end
  end
`else
  logic unused_starve_cfg;
  assign unused_starve_cfg = ^8'(STARVE_MAX);
  assign w_force           = 1'b0;
`endif

  always_comb begin
    w_grant   = 1'b0;
    w_take_bg = 1'b0;
    w_win     = '0;
    if (bus.req[0] && !w_force) begin
      w_grant = 1'b1;
    end else if (w_rr_found) begin
      w_grant   = 1'b1;
      w_take_bg = 1'b1;
      w_win     = w_rr_idx;
    end
  end

  always_comb begin
    w_win_addr = '0;
    for (int j = 0; j < NUM_REQ; j++) begin
      if (w_win == IDX_W'(j)) begin
        w_win_addr = bus.addr[j*ADDR_W +: ADDR_W];
      end
    end
  end

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_gnt     <= '0;
      r_gnt_idx <= '0;
      rom_en    <= 1'b0;
      rom_addra <= '0;
      r_rr_ptr  <= FIRST_BG;
    end else begin
      r_gnt     <= w_grant ? (NUM_REQ'(1) << w_win) : '0;
      r_gnt_idx <= w_win;
      rom_en    <= w_grant;
      if (w_grant) begin
        rom_addra <= w_win_addr;
      end
      if (w_take_bg) begin
        r_rr_ptr <= w_rr_next;
      end
    end
  end

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_pipe_vld <= '0;
      for (int s = 0; s < ROM_LAT; s++) begin
        r_pipe_idx[s] <= '0;
      end
    end else begin
      r_pipe_vld[0] <= |r_gnt;
      r_pipe_idx[0] <= r_gnt_idx;
      for (int s = 1; s < ROM_LAT; s++) begin
        r_pipe_vld[s] <= r_pipe_vld[s-1];
        r_pipe_idx[s] <= r_pipe_idx[s-1];
      end
    end
  end

  // rdata is captured on the same edge that loads the last pipeline stage.
  generate
    if (ROM_LAT == 1) begin : g_cap_direct
      assign w_cap = |r_gnt;
    end else begin : g_cap_pipe
      assign w_cap = r_pipe_vld[ROM_LAT-2];
    end
  endgenerate

  always_ff @(posedge vga_clk or negedge vga_rst_n) begin
    if (!vga_rst_n) begin
      r_rdata <= '0;
    end else if (w_cap) begin
      r_rdata <= rom_douta;
    end
  end

  assign bus.gnt         = r_gnt;
  assign bus.rdata_valid = r_pipe_vld[ROM_LAT-1] ? (NUM_REQ'(1) << r_pipe_idx[ROM_LAT-1]) : '0;
  assign bus.rdata       = r_rdata;
  assign busy            = |r_pipe_vld;

endmodule

`default_nettype wire

// File: tb/tb_font_rom_arbiter.sv
// ============================================================================
// tb_font_rom_arbiter : table-driven check of priority, round-robin, latency,
// mid-operation reset and (with FONT_ARB_STARVE_EN) the starvation slot.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_font_rom_arbiter;

  localparam logic [14:0] A1 = 15'h0101;
  localparam logic [14:0] A2 = 15'h0202;
  localparam logic [14:0] A3 = 15'h0303;

  logic        vga_clk = 1'b0;
  logic        vga_rst_n;
  logic [3:0]  req;
  logic [14:0] a0;
  logic        rom_en;
  logic [14:0] rom_addra;
  logic        rom_douta;
  logic        busy;
`ifdef FONT_ARB_STARVE_EN
  logic        starve_hit;
`endif

  int n_pass  = 0;
  int n_total = 0;

  always #5 vga_clk = ~vga_clk;

  font_rom_arbiter_if #(.NUM_REQ(4), .ADDR_W(15), .DATA_W(1)) bus ();
  assign bus.req  = req;
  assign bus.addr = {A3, A2, A1, a0};

  // ROM content model: parity of selected address bits
  assign rom_douta = ^(rom_addra & 15'h02B5);

  font_rom_arbiter #(
    .NUM_REQ   (4),
    .ADDR_W    (15),
    .DATA_W    (1),
    .ROM_LAT   (1),
    .STARVE_MAX(4)
  ) dut (
    .vga_clk   (vga_clk),
    .vga_rst_n (vga_rst_n),
    .bus       (bus.slave),
    .rom_en    (rom_en),
    .rom_addra (rom_addra),
    .rom_douta (rom_douta),
    .busy      (busy)
`ifdef FONT_ARB_STARVE_EN
    ,
    .starve_hit(starve_hit)
`endif
  );

  typedef struct {
    logic [3:0]  req;
    logic [14:0] a0;
    logic [3:0]  gnt;
    logic        en;
    logic [14:0] ra;
    logic [3:0]  vld;
    logic        rd;
    logic        bsy;
  } vec_t;

  vec_t vecs [26];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  initial begin
    logic [7:0] rd_bits;
    logic [3:0] exp_g;
    rd_bits = 8'b1011_0100;

    vecs[0]  = '{4'b0000, 15'h000, 4'b0000, 1'b0, 15'h000, 4'b0000, 1'b0, 1'b0};
    vecs[1]  = '{4'b0000, 15'h000, 4'b0000, 1'b0, 15'h000, 4'b0000, 1'b0, 1'b0};
    for (int t = 0; t < 8; t++) begin
      vecs[2+t] = '{4'b0001, 15'(t), 4'b0001, 1'b1, 15'(t),
                    (t == 0) ? 4'b0000 : 4'b0001, rd_bits[t], 1'(t != 0)};
    end
    vecs[10] = '{4'b0000, 15'h007, 4'b0000, 1'b0, 15'h007, 4'b0001, 1'b0, 1'b1};
    vecs[11] = '{4'b0000, 15'h007, 4'b0000, 1'b0, 15'h007, 4'b0000, 1'b0, 1'b0};
    vecs[12] = '{4'b1110, 15'h000, 4'b0010, 1'b1, A1,      4'b0000, 1'b0, 1'b0};
    vecs[13] = '{4'b1100, 15'h000, 4'b0100, 1'b1, A2,      4'b0010, 1'b1, 1'b1};
    vecs[14] = '{4'b1000, 15'h000, 4'b1000, 1'b1, A3,      4'b0100, 1'b1, 1'b1};
    vecs[15] = '{4'b0000, 15'h000, 4'b0000, 1'b0, A3,      4'b1000, 1'b0, 1'b1};
    vecs[16] = '{4'b1010, 15'h000, 4'b0010, 1'b1, A1,      4'b0000, 1'b0, 1'b0};
    vecs[17] = '{4'b1000, 15'h000, 4'b1000, 1'b1, A3,      4'b0010, 1'b1, 1'b1};
    vecs[18] = '{4'b1000, 15'h000, 4'b0000, 1'b0, A3,      4'b1000, 1'b0, 1'b1};
    vecs[19] = '{4'b1000, 15'h000, 4'b1000, 1'b1, A3,      4'b0000, 1'b0, 1'b0};
    vecs[20] = '{4'b0000, 15'h000, 4'b0000, 1'b0, A3,      4'b1000, 1'b0, 1'b1};
    vecs[21] = '{4'b0101, 15'h010, 4'b0001, 1'b1, 15'h010, 4'b0000, 1'b0, 1'b0};
    vecs[22] = '{4'b0101, 15'h011, 4'b0001, 1'b1, 15'h011, 4'b0001, 1'b1, 1'b1};
    vecs[23] = '{4'b0100, 15'h011, 4'b0100, 1'b1, A2,      4'b0001, 1'b0, 1'b1};
    vecs[24] = '{4'b0000, 15'h011, 4'b0000, 1'b0, A2,      4'b0100, 1'b1, 1'b1};
    vecs[25] = '{4'b0000, 15'h011, 4'b0000, 1'b0, A2,      4'b0000, 1'b1, 1'b0};

    req       = '0;
    a0        = '0;
    vga_rst_n = 1'b1;
    #2 vga_rst_n = 1'b0;
    #2;
    chk("rst_gnt",   32'(bus.gnt), 32'h0);
    chk("rst_vld",   32'(bus.rdata_valid), 32'h0);
    chk("rst_rdata", 32'(bus.rdata), 32'h0);
    chk("rst_en",    32'(rom_en), 32'h0);
    chk("rst_addra", 32'(rom_addra), 32'h0);
    chk("rst_busy",  32'(busy), 32'h0);
    @(posedge vga_clk);
    @(posedge vga_clk);
    #1 vga_rst_n = 1'b1;

    for (int c = 0; c < 10; c++) begin
      step();
      chk("idle_gnt",   32'(bus.gnt), 32'h0);
      chk("idle_en",    32'(rom_en), 32'h0);
      chk("idle_vld",   32'(bus.rdata_valid), 32'h0);
      chk("idle_busy",  32'(busy), 32'h0);
      chk("idle_addra", 32'(rom_addra), 32'h0);
    end

    for (int i = 0; i < 26; i++) begin
      req = vecs[i].req;
      a0  = vecs[i].a0;
      step();
      chk($sformatf("v%0d_gnt", i),   32'(bus.gnt), 32'(vecs[i].gnt));
      chk($sformatf("v%0d_en", i),    32'(rom_en), 32'(vecs[i].en));
      chk($sformatf("v%0d_addra", i), 32'(rom_addra), 32'(vecs[i].ra));
      chk($sformatf("v%0d_vld", i),   32'(bus.rdata_valid), 32'(vecs[i].vld));
      chk($sformatf("v%0d_rdata", i), 32'(bus.rdata), 32'(vecs[i].rd));
      chk($sformatf("v%0d_busy", i),  32'(busy), 32'(vecs[i].bsy));
`ifdef FONT_ARB_STARVE_EN
      chk($sformatf("v%0d_starve", i), 32'(starve_hit), 32'h0);
`endif
    end

    // Reset while requester 3's read is in flight
    req = 4'b1000;
    step();
    chk("mid_gnt3", 32'(bus.gnt), 32'h8);
    req = 4'b0000;
    #2 vga_rst_n = 1'b0;
    #1;
    chk("mid_gnt",   32'(bus.gnt), 32'h0);
    chk("mid_vld",   32'(bus.rdata_valid), 32'h0);
    chk("mid_en",    32'(rom_en), 32'h0);
    chk("mid_addra", 32'(rom_addra), 32'h0);
    chk("mid_rdata", 32'(bus.rdata), 32'h0);
    chk("mid_busy",  32'(busy), 32'h0);
    step();
    chk("mid_vld_hold", 32'(bus.rdata_valid), 32'h0);
    #2 vga_rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      step();
      chk("post_vld", 32'(bus.rdata_valid), 32'h0);
    end
    req = 4'b1110;
    step();
    chk("post_first_bg", 32'(bus.gnt), 32'h2);

    // Pointer sits at 2 here; reset must return it to 1
    req = 4'b0000;
    step();
    vga_rst_n = 1'b0;
    #2 vga_rst_n = 1'b1;
    req = 4'b0110;
    step();
    chk("ptr_restart", 32'(bus.gnt), 32'h2);
    req = 4'b0000;
    step();

    // Requester 0 streaming with requester 1 waiting
    req = 4'b0011;
    a0  = 15'h020;
    for (int k = 1; k <= 7; k++) begin
      step();
`ifdef FONT_ARB_STARVE_EN
      exp_g = (k == 5) ? 4'b0010 : 4'b0001;
      chk($sformatf("starve%0d_hit", k), 32'(starve_hit), 32'(k == 5));
      chk($sformatf("starve%0d_addra", k), 32'(rom_addra), (k == 5) ? 32'(A1) : 32'h020);
`else
      exp_g = 4'b0001;
`endif
      chk($sformatf("starve%0d_gnt", k), 32'(bus.gnt), 32'(exp_g));
    end
    req = 4'b0000;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

`default_nettype wire
